// File: rtl/idma_init_pattern_sub.sv
// Responder end of the iDMA INIT protocol: each accepted request yields one generated
// data word (zero, constant byte, counter or LFSR), queued in order in a small response FIFO.
module idma_init_pattern_sub #(
    parameter int unsigned DataWidth = 32'd64,
    parameter int unsigned CfgWidth  = 32'd32,
    parameter int unsigned IdWidth   = 32'd4,
    parameter int unsigned RspDepth  = 32'd2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [CfgWidth-1:0]  req_cfg_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_init_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 busy_o
);

    localparam int unsigned Lanes = DataWidth / 32;
    localparam int unsigned PtrW  = (RspDepth > 32'd1) ? $clog2(RspDepth) : 32'd1;
    localparam int unsigned CntW  = $clog2(RspDepth + 32'd1);

    localparam logic [1:0]  ModeZero  = 2'b00;
    localparam logic [1:0]  ModeConst = 2'b01;
    localparam logic [1:0]  ModeCount = 2'b10;
    localparam logic [1:0]  ModeLfsr  = 2'b11;
    localparam logic [31:0] LfsrTaps  = 32'h8020_0003;

    // Galois right-shift LFSR step; a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] x;
        x = s >> 1;
        if (s[0]) begin
            x = x ^ LfsrTaps;
        end else begin
            x = x;
        end
        return x;
    endfunction

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] n;
        if (p == PtrW'(RspDepth - 32'd1)) begin
            n = '0;
        end else begin
            n = p + PtrW'(1);
        end
        return n;
    endfunction

    logic [31:0]          cnt_r;
    logic [31:0]          lfsr_r;
    logic [DataWidth-1:0] data_mem_r [RspDepth];
    logic [IdWidth-1:0]   id_mem_r   [RspDepth];
    logic [PtrW-1:0]      wr_ptr_r;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [CntW-1:0]      count_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 accept_s;
    logic                 retire_s;
    logic [1:0]           mode_s;
    logic                 seed_en_s;
    logic [7:0]           fill_s;
    logic [31:0]          seed_s;
    logic [31:0]          cnt_base_s;
    logic [31:0]          lfsr_base_s;
    logic [DataWidth-1:0] gen_data_s;
    logic                 unused_cfg_s;

    assign full_s      = (count_r == CntW'(RspDepth));
    assign empty_s     = (count_r == CntW'(0));
    assign req_ready_o = ~full_s;
    assign accept_s    = req_valid_i & ~full_s;
    assign retire_s    = ~empty_s & rsp_ready_i;
    assign rsp_valid_o = ~empty_s;
    assign busy_o      = ~empty_s;

    assign mode_s       = req_cfg_i[1:0];
    assign seed_en_s    = req_cfg_i[2];
    assign fill_s       = req_cfg_i[15:8];
    assign seed_s       = {16'h0000, req_cfg_i[31:16]};
    assign unused_cfg_s = ^req_cfg_i;

    // Per-mode base values; an explicit seed of zero would lock the LFSR, so it becomes 1.
    always_comb begin
        cnt_base_s  = cnt_r;
        lfsr_base_s = lfsr_r;
        if (seed_en_s) begin
            cnt_base_s  = seed_s;
            lfsr_base_s = (seed_s == 32'h0) ? 32'h0000_0001 : seed_s;
        end else begin
            cnt_base_s  = cnt_r;
            lfsr_base_s = lfsr_r;
        end
    end

    // Response word generation for the request currently presented.
    always_comb begin
        gen_data_s = '0;
        case (mode_s)
            ModeZero: begin
                gen_data_s = '0;
            end
            ModeConst: begin
                gen_data_s = {(DataWidth / 8){fill_s}};
            end
            ModeCount: begin
                for (int k = 0; k < int'(Lanes); k++) begin
                    gen_data_s[32*k +: 32] = cnt_base_s + 32'(k);
                end
            end
            ModeLfsr: begin
                for (int k = 0; k < int'(Lanes); k++) begin
                    gen_data_s[32*k +: 32] = lfsr_base_s;
                end
            end
            default: begin
                gen_data_s = '0;
            end
        endcase
    end

    // Pattern state advances only on an accepted request of its own mode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r  <= 32'h0000_0000;
            lfsr_r <= 32'h0000_0001;
        end else if (accept_s && (mode_s == ModeCount)) begin
            cnt_r  <= cnt_base_s + 32'(Lanes);
        end else if (accept_s && (mode_s == ModeLfsr)) begin
            lfsr_r <= lfsr_step(lfsr_base_s);
        end
    end

    // Response FIFO storage and pointers; simultaneous accept and retire keep the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RspDepth); i++) begin
                data_mem_r[i] <= '0;
                id_mem_r[i]   <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) begin
                data_mem_r[wr_ptr_r] <= gen_data_s;
                id_mem_r[wr_ptr_r]   <= req_id_i;
                wr_ptr_r             <= ptr_next(wr_ptr_r);
            end
            if (retire_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({accept_s, retire_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head of queue drives the response; zeroed while nothing is queued.
    always_comb begin
        rsp_init_o = '0;
        rsp_id_o   = '0;
        if (empty_s) begin
            rsp_init_o = '0;
            rsp_id_o   = '0;
        end else begin
            rsp_init_o = data_mem_r[rd_ptr_r];
            rsp_id_o   = id_mem_r[rd_ptr_r];
        end
    end

endmodule
